// File: rtl/apbdma_stream_downsizer.sv
// ----------------------------------------------------------------------------
// apbdma_stream_downsizer
//
// Splits each wide input word (data, byte strobes, last marker) into
// InDataWidth/OutDataWidth narrow beats over a valid/ready stream. Sits
// between the DMA read-side buffer and the narrow APB write engine. The
// final beat of a word can hand over directly to the next word, so a
// continuous input stream produces a continuous output stream.
//
// Optional feature (compile-time macro APBDMA_DOWNSIZER_SKIP_EMPTY_EN):
//   beats whose strobe slice is all zero are skipped. A word with an
//   all-zero strobe still emits slice 0 (strb 0) so its last marker is kept.
//
// Parameters:
//   InDataWidth  - input data width (multiple of 8 and of OutDataWidth)
//   OutDataWidth - output data width (multiple of 8)
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_i   - synchronous active-high reset
//   data_i  - input word
//   strb_i  - input byte strobes
//   last_i  - input word ends a transfer
//   valid_i - input valid
//   ready_o - input accepted when valid_i && ready_o
//   data_o  - output beat (slice idx_q of the held word)
//   strb_o  - output beat strobes
//   last_o  - final beat of a word that carried last_i
//   valid_o - output valid
//   ready_i - output accepted when valid_o && ready_i
//   busy_o  - holding register occupied
// ----------------------------------------------------------------------------
module apbdma_stream_downsizer #(
    parameter int InDataWidth  = 64,
    parameter int OutDataWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [InDataWidth-1:0]    data_i,
    input  logic [InDataWidth/8-1:0]  strb_i,
    input  logic                      last_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [OutDataWidth-1:0]   data_o,
    output logic [OutDataWidth/8-1:0] strb_o,
    output logic                      last_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      busy_o
);

    localparam int unsigned Ratio        = InDataWidth / OutDataWidth;
    localparam int unsigned IdxWidth     = (Ratio > 1) ? $clog2(Ratio) : 1;
    localparam int unsigned InStrbWidth  = InDataWidth / 8;
    localparam int unsigned OutStrbWidth = OutDataWidth / 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                    state_q;
    logic [InDataWidth-1:0]    data_q;
    logic [InStrbWidth-1:0]    strb_q;
    logic                      last_q;
    logic [IdxWidth-1:0]       idx_q;

    logic [OutDataWidth-1:0]   data_sel;
    logic [OutStrbWidth-1:0]   strb_sel;
    logic [IdxWidth-1:0]       first_idx;
    logic [IdxWidth-1:0]       next_idx;
    logic                      is_final;

    // Current beat selection from the holding register.
    always_comb begin
        data_sel = '0;
        strb_sel = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (idx_q == IdxWidth'(k)) begin
                data_sel = data_q[k*OutDataWidth +: OutDataWidth];
                strb_sel = strb_q[k*OutStrbWidth +: OutStrbWidth];
            end
        end
    end

`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
    logic [Ratio-1:0]    nz_in;
    logic [Ratio-1:0]    nz_q;
    logic [IdxWidth-1:0] final_idx;

    // Per-slice "has any strobe" masks for the incoming and held words.
    always_comb begin
        nz_in = '0;
        nz_q  = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            nz_in[k] = |strb_i[k*OutStrbWidth +: OutStrbWidth];
            nz_q[k]  = |strb_q[k*OutStrbWidth +: OutStrbWidth];
        end
    end

    // Lowest nonzero slice of the incoming word; slice 0 if none, so an
    // all-zero word still produces one beat carrying its last marker.
    always_comb begin : first_enc
        logic found;
        found     = 1'b0;
        first_idx = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (nz_in[k] && !found) begin
                first_idx = IdxWidth'(k);
                found     = 1'b1;
            end
        end
    end

    // Highest nonzero slice of the held word marks the final beat.
    always_comb begin
        final_idx = '0;
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (nz_q[k]) begin
                final_idx = IdxWidth'(k);
            end
        end
    end

    // Next nonzero slice strictly above the current index.
    always_comb begin : next_enc
        logic found;
        found    = 1'b0;
        next_idx = idx_q;
        for (int unsigned k = 0; k < Ratio; k++) begin
            if (nz_q[k] && (IdxWidth'(k) > idx_q) && !found) begin
                next_idx = IdxWidth'(k);
                found    = 1'b1;
            end
        end
    end

    assign is_final = (idx_q == final_idx);
`else
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Ratio - 1);

    assign first_idx = '0;
    assign next_idx  = idx_q + IdxWidth'(1);
    assign is_final  = (idx_q == LastIdx);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_q  <= data_i;
                        strb_q  <= strb_i;
                        last_q  <= last_i;
                        idx_q   <= first_idx;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (ready_i) begin
                        if (!is_final) begin
                            idx_q <= next_idx;
                        end else if (valid_i) begin
                            // Final beat handshake doubles as input accept.
                            data_q <= data_i;
                            strb_q <= strb_i;
                            last_q <= last_i;
                            idx_q  <= first_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while reset is held so they are defined even
    // before the first clock edge clears the registers.
    assign busy_o  = !rst_i && (state_q == SEND);
    assign valid_o = busy_o;
    assign ready_o = !rst_i && ((state_q == IDLE) || (ready_i && is_final));
    assign last_o  = valid_o && last_q && is_final;
    assign data_o  = rst_i ? '0 : data_sel;
    assign strb_o  = rst_i ? '0 : strb_sel;

endmodule

// File: tb/tb_apbdma_stream_downsizer.sv
// ----------------------------------------------------------------------------
// tb_apbdma_stream_downsizer
//
// Three downsizer instances (64->32, 128->32, 32->32) share clock, reset,
// input buses and ready_i; only the instance selected by `sel` receives
// valid_i. Expected beats are pushed to a queue on input acceptance and
// compared as the selected instance hands beats out.
// ----------------------------------------------------------------------------
module tb_apbdma_stream_downsizer;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] d_in = '0;
    logic [15:0]  s_in = '0;
    logic         l_in = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic         rdy_in = 1'b1;
    int unsigned  sel = 0;

    logic        r0, r1, r2, lo0, lo1, lo2, vo0, vo1, vo2, b0, b1, b2;
    logic [31:0] do0, do1, do2;
    logic [3:0]  so0, so1, so2;

    logic        mon_valid, mon_ready, mon_busy, mon_last;
    logic [31:0] mon_data;
    logic [3:0]  mon_strb;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    apbdma_stream_downsizer #(.InDataWidth(64), .OutDataWidth(32)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(d_in[63:0]), .strb_i(s_in[7:0]),
        .last_i(l_in), .valid_i(v0), .ready_o(r0), .data_o(do0), .strb_o(so0),
        .last_o(lo0), .valid_o(vo0), .ready_i(rdy_in), .busy_o(b0)
    );

    apbdma_stream_downsizer #(.InDataWidth(128), .OutDataWidth(32)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(d_in), .strb_i(s_in),
        .last_i(l_in), .valid_i(v1), .ready_o(r1), .data_o(do1), .strb_o(so1),
        .last_o(lo1), .valid_o(vo1), .ready_i(rdy_in), .busy_o(b1)
    );

    apbdma_stream_downsizer #(.InDataWidth(32), .OutDataWidth(32)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(d_in[31:0]), .strb_i(s_in[3:0]),
        .last_i(l_in), .valid_i(v2), .ready_o(r2), .data_o(do2), .strb_o(so2),
        .last_o(lo2), .valid_o(vo2), .ready_i(rdy_in), .busy_o(b2)
    );

    always_comb begin
        mon_valid = vo0; mon_ready = r0; mon_busy = b0;
        mon_last  = lo0; mon_data  = do0; mon_strb = so0;
        if (sel == 1) begin
            mon_valid = vo1; mon_ready = r1; mon_busy = b1;
            mon_last  = lo1; mon_data  = do1; mon_strb = so1;
        end else if (sel == 2) begin
            mon_valid = vo2; mon_ready = r2; mon_busy = b2;
            mon_last  = lo2; mon_data  = do2; mon_strb = so2;
        end
    end

    // Scoreboard: every output handshake must match the next expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (!rst && mon_valid && rdy_in) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_extra: got data=%h strb=%h last=%b, required no beat",
                         mon_data, mon_strb, mon_last);
            end else begin
                e = exp_q.pop_front();
                if ({mon_data, mon_strb, mon_last} !== {e.data, e.strb, e.last}) begin
                    errors++;
                    $display("FAIL beat: got data=%h strb=%h last=%b, required data=%h strb=%h last=%b",
                             mon_data, mon_strb, mon_last, e.data, e.strb, e.last);
                end
            end
        end
    end

    function automatic int unsigned ratio_of(input int unsigned s);
        return (s == 0) ? 2 : (s == 1) ? 4 : 1;
    endfunction

    // Reference split of one word into expected 32-bit beats.
    task automatic push_expected(input int unsigned ratio, input logic [127:0] d,
                                 input logic [15:0] s, input logic l);
        int unsigned hi;
        beat_t       b;
        hi = ratio - 1;
`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
        begin
            bit any;
            any = 1'b0;
            for (int unsigned k = 0; k < ratio; k++) begin
                if (s[k*4 +: 4] != 4'h0) begin
                    any = 1'b1;
                    hi  = k;
                end
            end
            if (!any) begin
                b.data = d[31:0];
                b.strb = 4'h0;
                b.last = l;
                exp_q.push_back(b);
                return;
            end
        end
`endif
        for (int unsigned k = 0; k < ratio; k++) begin
`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
            if (s[k*4 +: 4] == 4'h0) continue;
`endif
            b.data = d[k*32 +: 32];
            b.strb = s[k*4 +: 4];
            b.last = l && (k == hi);
            exp_q.push_back(b);
        end
    endtask

    task automatic set_valid(input logic v);
        v0 = v && (sel == 0);
        v1 = v && (sel == 1);
        v2 = v && (sel == 2);
    endtask

    // Present a word and hold it until accepted; returns #1 after the
    // accepting edge with valid still asserted.
    task automatic drive_word(input logic [127:0] d, input logic [15:0] s, input logic l);
        bit accepted;
        accepted = 1'b0;
        d_in = d; s_in = s; l_in = l;
        set_valid(1'b1);
        for (int i = 0; i < 64 && !accepted; i++) begin
            @(negedge clk);
            if (mon_ready) begin
                push_expected(ratio_of(sel), d, s, l);
                accepted = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL accept_timeout: got ready_o never high, required acceptance within 64 cycles");
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (mon_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: got valid_o=%b after drain, required 0", name, mon_valid);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        set_valid(1'b0);
        @(negedge clk);
        checks++;
        if ({mon_valid, mon_ready, mon_busy, mon_last, mon_data, mon_strb} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b r=%b b=%b l=%b d=%h s=%h, required all 0",
                     mon_valid, mon_ready, mon_busy, mon_last, mon_data, mon_strb);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mon_valid, mon_ready, mon_busy} !== 3'b010) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b ready=%b busy=%b, required 0 1 0",
                     mon_valid, mon_ready, mon_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_split();
        sel = 0;
        rdy_in = 1'b1;
        drive_word(128'h1122334455667788, 16'h00FF, 1'b1);
        set_valid(1'b0);
        @(negedge clk);
        checks++;
        if ({mon_valid, mon_data, mon_strb, mon_last} !== {1'b1, 32'h55667788, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL split_beat0: got v=%b d=%h s=%h l=%b, required 1 55667788 f 0",
                     mon_valid, mon_data, mon_strb, mon_last);
        end
        @(negedge clk);
        checks++;
        if ({mon_valid, mon_data, mon_strb, mon_last} !== {1'b1, 32'h11223344, 4'hF, 1'b1}) begin
            errors++;
            $display("FAIL split_beat1: got v=%b d=%h s=%h l=%b, required 1 11223344 f 1",
                     mon_valid, mon_data, mon_strb, mon_last);
        end
        @(negedge clk);
        checks++;
        if (mon_valid !== 1'b0) begin
            errors++;
            $display("FAIL split_end: got valid_o=%b, required 0", mon_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        sel = 0;
        rdy_in = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    drive_word({64'h0, $urandom, $urandom}, {8'h0, 4'(k + 1), 4'(8 - k)}, 1'(k == 3));
                set_valid(1'b0);
            end
            begin
                for (int i = 0; i < 20 && !mon_valid; i++) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if ({mon_valid, mon_ready} !== {1'b1, 1'((i % 2) == 1)}) begin
                        errors++;
                        $display("FAIL b2b_beat%0d: got valid=%b ready=%b, required 1 %b",
                                 i, mon_valid, mon_ready, 1'((i % 2) == 1));
                    end
                    if (i < 7) @(negedge clk);
                end
            end
        join
        wait_drain("b2b");
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        sel = 0;
        rdy_in = 1'b0;
        drive_word(128'hDEADBEEFCAFEF00D, 16'h003C, 1'b0);
        set_valid(1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({mon_valid, mon_ready, mon_data, mon_strb, mon_last} !==
                {1'b1, 1'b0, 32'hCAFEF00D, 4'hC, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b r=%b d=%h s=%h l=%b, required 1 0 cafef00d c 0",
                         i, mon_valid, mon_ready, mon_data, mon_strb, mon_last);
            end
        end
        @(posedge clk); #1;
        rdy_in = 1'b1;
        wait_drain("bp");
        @(posedge clk); #1;
    endtask

    task automatic test_skip_empty();
        sel = 1;
        rdy_in = 1'b1;
        drive_word(128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000, 16'h00F0, 1'b1);
        set_valid(1'b0);
        wait_drain("skip_one");
        @(posedge clk); #1;
        drive_word(128'h44444444_33333333_22222222_11111111, 16'h0000, 1'b1);
        set_valid(1'b0);
        wait_drain("skip_zero");
        @(posedge clk); #1;
        drive_word(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 16'h3001, 1'b1);
        set_valid(1'b0);
        wait_drain("skip_gap");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_word();
        sel = 1;
        rdy_in = 1'b1;
        drive_word(128'h01234567_89ABCDEF_FEDCBA98_76543210, 16'hFFFF, 1'b1);
        set_valid(1'b0);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mon_valid, mon_ready, mon_busy, mon_last, mon_data, mon_strb} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got v=%b r=%b b=%b l=%b d=%h s=%h, required all 0",
                     mon_valid, mon_ready, mon_busy, mon_last, mon_data, mon_strb);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({mon_valid, mon_busy, mon_ready} !== 3'b001) begin
                errors++;
                $display("FAIL rst_mid_idle%0d: got valid=%b busy=%b ready=%b, required 0 0 1",
                         i, mon_valid, mon_busy, mon_ready);
            end
        end
        @(posedge clk); #1;
        drive_word(128'hA5A5A5A3_A5A5A5A2_A5A5A5A1_A5A5A5A0, 16'hFFFF, 1'b1);
        set_valid(1'b0);
        wait_drain("rst_mid_next");
        @(posedge clk); #1;
    endtask

    task automatic test_ratio_one();
        sel = 2;
        rdy_in = 1'b1;
        fork
            begin
                drive_word(128'h0000_0000_0000_0000_0000_0000_1234_5678, 16'h000F, 1'b0);
                drive_word(128'h0000_0000_0000_0000_0000_0000_9ABC_DEF0, 16'h0005, 1'b0);
                drive_word(128'h0000_0000_0000_0000_0000_0000_0F0F_0F0F, 16'h0009, 1'b1);
                set_valid(1'b0);
            end
            begin
                for (int i = 0; i < 20 && !mon_valid; i++) @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if ({mon_valid, mon_ready} !== 2'b11) begin
                        errors++;
                        $display("FAIL r1_rate%0d: got valid=%b ready=%b, required 1 1",
                                 i, mon_valid, mon_ready);
                    end
                    if (i < 2) @(negedge clk);
                end
            end
        join
        wait_drain("r1");
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic_split();
        test_back_to_back();
        test_backpressure();
        test_skip_empty();
        test_reset_mid_word();
        test_ratio_one();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
